// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared types for the execute-stage ALU: the ALUType encoding produced by
// the ALU control decoder, the execute FSM states, the default datapath
// width, and a helper that recognises the two shift operations.
// Build option: ALU_FAST_SHIFT_EN (see alu_exec_unit) does not affect
// anything in this package.
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int XLEN_DEF = 32;

  // Encodings 9..15 are also undefined; they are detected by bit 3 and
  // handled exactly like NDEF.
  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    SLL  = 4'd2,
    SLT  = 4'd3,
    XOR  = 4'd4,
    SRL  = 4'd5,
    OR   = 4'd6,
    AND  = 4'd7,
    NDEF = 4'd8
  } alu_type_e;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD
  } alu_state_e;

  // True for the two operations that go through the serial shifter.
  function automatic logic isShiftOp(input logic [3:0] op);
    return (alu_type_e'(op) == SLL) || (alu_type_e'(op) == SRL);
  endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// ---------------------------------------------------------------------------
// alu_serial_shifter
// One-bit-per-cycle logical shifter used by alu_exec_unit for SLL/SRL.
// A load captures the operand, the direction and the shift amount; the
// accumulator then moves one bit per clock until the count runs out.
// Ports:
//   clk, rst  : clock (rising edge) and asynchronous active-high reset
//   i_load    : capture i_data / i_dir / i_shamt this cycle
//   i_dir     : 0 = shift left, 1 = logical shift right (zero fill)
//   i_shamt   : number of positions to shift (must be non-zero on load)
//   i_data    : operand to shift
//   o_busy    : shift in progress (count non-zero)
//   o_done    : the shift performed on the coming edge is the last one
//   o_next    : accumulator value after the shift on the coming edge
// ---------------------------------------------------------------------------
module alu_serial_shifter #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic               i_dir,
  input  logic [SHAMT_W-1:0] i_shamt,
  input  logic [XLEN-1:0]    i_data,
  output logic               o_busy,
  output logic               o_done,
  output logic [XLEN-1:0]    o_next
);

  logic [XLEN-1:0]    r_acc;
  logic [SHAMT_W-1:0] r_cnt;
  logic               r_dir;

  // The next accumulator value is exposed so the parent can register the
  // final result on the same edge as the last shift, saving a cycle.
  assign o_next = r_dir ? (r_acc >> 1) : (r_acc << 1);
  assign o_busy = (r_cnt != '0);
  assign o_done = (r_cnt == SHAMT_W'(1));

  // Accumulator and count: a load always wins so a new shift can start
  // immediately after the previous one has finished.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_dir <= 1'b0;
    end else if (i_load) begin
      r_acc <= i_data;
      r_cnt <= i_shamt;
      r_dir <= i_dir;
    end else if (o_busy) begin
      r_acc <= o_next;
      r_cnt <= r_cnt - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
// Execute-stage ALU with valid/ready handshakes on both sides. Takes the
// 4-bit ALUType and two operands, and presents a registered result with
// zero/illegal flags toward the EX/MEM register.
// Ports:
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready : upstream handshake (op accepted when both high)
//   alu_type            : 0 ADD,1 SUB,2 SLL,3 SLT,4 XOR,5 SRL,6 OR,7 AND,8+ NDEF
//   src1, src2          : operands; shift amount is src2[SHAMT_W-1:0]
//   out_valid/out_ready : downstream handshake for the result
//   result, zero        : registered result and result==0 flag
//   illegal             : the op that produced result was undefined
// Build option:
//   ALU_FAST_SHIFT_EN defined   -> shifts use a combinational barrel shifter,
//                                  every op has 1-cycle latency.
//   ALU_FAST_SHIFT_EN undefined -> shifts run one bit per cycle through
//                                  alu_serial_shifter (latency shamt+1).
// ---------------------------------------------------------------------------
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_type,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  alu_state_e      r_state;
  logic            r_outValid;
  logic [XLEN-1:0] r_result;
  logic            r_zero;
  logic            r_illegal;

  logic [SHAMT_W-1:0] w_shamt;
  logic               w_accept;
  logic               w_illegal;
  logic [XLEN-1:0]    w_aluResult;
  logic               w_serialStart;
  logic               w_shiftBusy;
  logic               w_shiftDone;
  logic [XLEN-1:0]    w_shiftNext;

  assign w_shamt   = src2[SHAMT_W-1:0];
  assign w_illegal = alu_type[3];

  // A new op may enter only from IDLE, and only when the output register is
  // empty or is being drained this very cycle.
  assign in_ready = (r_state == IDLE) && !w_shiftBusy && (!r_outValid || out_ready);
  assign w_accept = in_valid && in_ready;

`ifdef ALU_FAST_SHIFT_EN
  assign w_serialStart = 1'b0;
  assign w_shiftBusy   = 1'b0;
  assign w_shiftDone   = 1'b0;
  assign w_shiftNext   = '0;
`else
  logic w_isShift;

  // Zero-distance shifts skip the serial path and complete like any other op.
  assign w_isShift     = isShiftOp(alu_type);
  assign w_serialStart = w_accept && w_isShift && (w_shamt != '0);

  alu_serial_shifter #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_serialStart),
    .i_dir   (alu_type_e'(alu_type) == SRL),
    .i_shamt (w_shamt),
    .i_data  (src1),
    .o_busy  (w_shiftBusy),
    .o_done  (w_shiftDone),
    .o_next  (w_shiftNext)
  );
`endif

  // Single-cycle datapath. In the serial build the shift entries only ever
  // see a zero shift amount, so they pass src1 through instead of building
  // a barrel shifter.
  always_comb begin
    w_aluResult = '0;
    case (alu_type_e'(alu_type))
      ADD: w_aluResult = src1 + src2;
      SUB: w_aluResult = src1 - src2;
`ifdef ALU_FAST_SHIFT_EN
      SLL: w_aluResult = src1 << w_shamt;
      SRL: w_aluResult = src1 >> w_shamt;
`else
      SLL: w_aluResult = src1;
      SRL: w_aluResult = src1;
`endif
      SLT: w_aluResult = {{(XLEN-1){1'b0}}, ($signed(src1) < $signed(src2))};
      XOR: w_aluResult = src1 ^ src2;
      OR:  w_aluResult = src1 | src2;
      AND: w_aluResult = src1 & src2;
      default: w_aluResult = '0;
    endcase
  end

  // Execute FSM with registered outputs. IDLE covers single-cycle ops and
  // output backpressure; SHIFT waits for the serial shifter; HOLD parks a
  // finished shift until the consumer takes it. When the consumer is ready
  // as a shift finishes, HOLD is bypassed and IDLE's own ready logic drains
  // the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_outValid <= 1'b0;
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_serialStart) begin
              r_outValid <= 1'b0;
              r_state    <= SHIFT;
            end else begin
              r_result   <= w_aluResult;
              r_zero     <= (w_aluResult == '0);
              r_illegal  <= w_illegal;
              r_outValid <= 1'b1;
            end
          end else if (r_outValid && out_ready) begin
            r_outValid <= 1'b0;
          end
        end
        SHIFT: begin
          if (w_shiftDone) begin
            r_result   <= w_shiftNext;
            r_zero     <= (w_shiftNext == '0);
            r_illegal  <= 1'b0;
            r_outValid <= 1'b1;
            r_state    <= out_ready ? IDLE : HOLD;
          end
        end
        HOLD: begin
          if (r_outValid && out_ready) begin
            r_outValid <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid = r_outValid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_unit
// Directed self-checking bench for alu_exec_unit. Inputs are driven and
// outputs sampled just after the falling edge. Shift latency expectations
// follow the ALU_FAST_SHIFT_EN build option.
// ---------------------------------------------------------------------------
module tb_alu_exec_unit;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_type = 4'd0;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int errors = 0;
  int checks = 0;

`ifdef ALU_FAST_SHIFT_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  alu_exec_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_type  (alu_type),
    .src1      (src1),
    .src2      (src2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  // Drive one upstream op (or idle the bus when v is 0).
  task automatic applyStimulus(input logic v, input logic [3:0] t, input logic [31:0] a, input logic [31:0] b);
    in_valid = v;
    alu_type = t;
    src1     = a;
    src2     = b;
  endtask

  task automatic nextCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    applyStimulus(1'b0, 4'd0, 32'h0, 32'h0);
    out_ready = 1'b1;
    repeat (2) nextCycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("[TB] FAIL reset_result: got %h want 00000000", result); end
    checks++; if (zero !== 1'b0) begin errors++; $display("[TB] FAIL reset_zero: got %b want 0", zero); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("[TB] FAIL reset_illegal: got %b want 0", illegal); end
    rst = 1'b0;
    nextCycle();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  t[3]    = '{ADD, ADD, OR};
    logic [31:0] a[3]    = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_00F0};
    logic [31:0] b[3]    = '{32'h0000_0001, 32'h0000_0001, 32'h0000_000F};
    logic [31:0] expR[3] = '{32'h8000_0000, 32'h0000_0000, 32'h0000_00FF};
    logic        expZ[3] = '{1'b0, 1'b1, 1'b0};
    applyStimulus(1'b1, t[0], a[0], b[0]);
    for (int i = 0; i < 3; i++) begin
      checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready); end
      nextCycle();
      if (i < 2) applyStimulus(1'b1, t[i+1], a[i+1], b[i+1]);
      else       applyStimulus(1'b0, 4'd0, 32'h0, 32'h0);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid[%0d]: got %b want 1", i, out_valid); end
      checks++; if (result !== expR[i]) begin errors++; $display("[TB] FAIL b2b_result[%0d]: got %h want %h", i, result, expR[i]); end
      checks++; if (zero !== expZ[i]) begin errors++; $display("[TB] FAIL b2b_zero[%0d]: got %b want %b", i, zero, expZ[i]); end
    end
    nextCycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_sub_slt();
    logic [3:0]  t[4]    = '{SUB, SLT, SLT, AND};
    logic [31:0] a[4]    = '{32'h5, 32'hFFFF_FFFF, 32'h1, 32'h0000_F0F0};
    logic [31:0] b[4]    = '{32'h5, 32'h1, 32'hFFFF_FFFF, 32'h0000_FF00};
    logic [31:0] expR[4] = '{32'h0, 32'h1, 32'h0, 32'h0000_F000};
    logic        expZ[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, t[i], a[i], b[i]);
      nextCycle();
      applyStimulus(1'b0, 4'd0, 32'h0, 32'h0);
      checks++; if (result !== expR[i]) begin errors++; $display("[TB] FAIL arith_result[%0d]: got %h want %h", i, result, expR[i]); end
      checks++; if (zero !== expZ[i]) begin errors++; $display("[TB] FAIL arith_zero[%0d]: got %b want %b", i, zero, expZ[i]); end
      checks++; if (illegal !== 1'b0) begin errors++; $display("[TB] FAIL arith_illegal[%0d]: got %b want 0", i, illegal); end
      nextCycle();
    end
  endtask

  task automatic test_shift();
    logic [3:0]  t[5]    = '{SLL, SRL, SLL, SRL, SLL};
    logic [31:0] a[5]    = '{32'h1, 32'h8000_0000, 32'h0000_ABCD, 32'hF000_0000, 32'h8000_0001};
    logic [31:0] b[5]    = '{32'h23, 32'h1F, 32'h20, 32'h4, 32'h1};
    logic [31:0] expR[5] = '{32'h8, 32'h1, 32'h0000_ABCD, 32'h0F00_0000, 32'h2};
    int          sh[5]   = '{3, 31, 0, 4, 1};
    for (int i = 0; i < 5; i++) begin
      int expLat;
      int lat    = 0;
      int stalls = 0;
      bit seen   = 1'b0;
      expLat = (FAST || sh[i] == 0) ? 1 : sh[i] + 1;
      applyStimulus(1'b1, t[i], a[i], b[i]);
      for (int c = 1; c <= 64 && !seen; c++) begin
        nextCycle();
        if (c == 1) applyStimulus(1'b0, 4'd0, 32'h0, 32'h0);
        if (out_valid === 1'b1) begin seen = 1'b1; lat = c; end
        else if (in_ready === 1'b0) stalls++;
      end
      checks++; if (!seen) begin errors++; $display("[TB] FAIL shift_timeout[%0d]: got no out_valid in 64 cycles want latency %0d", i, expLat); end
      checks++; if (lat != expLat) begin errors++; $display("[TB] FAIL shift_latency[%0d]: got %0d want %0d", i, lat, expLat); end
      checks++; if (stalls != expLat - 1) begin errors++; $display("[TB] FAIL shift_in_ready_low[%0d]: got %0d cycles want %0d", i, stalls, expLat - 1); end
      checks++; if (result !== expR[i]) begin errors++; $display("[TB] FAIL shift_result[%0d]: got %h want %h", i, result, expR[i]); end
      checks++; if (zero !== 1'b0) begin errors++; $display("[TB] FAIL shift_zero[%0d]: got %b want 0", i, zero); end
      nextCycle();
    end
  endtask

  task automatic test_illegal();
    applyStimulus(1'b1, 4'd9, 32'h3, 32'h4);
    nextCycle();
    applyStimulus(1'b1, ADD, 32'h2, 32'h3);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL ndef_valid: got %b want 1", out_valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("[TB] FAIL ndef_result: got %h want 00000000", result); end
    checks++; if (zero !== 1'b1) begin errors++; $display("[TB] FAIL ndef_zero: got %b want 1", zero); end
    checks++; if (illegal !== 1'b1) begin errors++; $display("[TB] FAIL ndef_illegal: got %b want 1", illegal); end
    nextCycle();
    applyStimulus(1'b0, 4'd0, 32'h0, 32'h0);
    checks++; if (result !== 32'h5) begin errors++; $display("[TB] FAIL after_ndef_result: got %h want 00000005", result); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("[TB] FAIL after_ndef_illegal: got %b want 0", illegal); end
    checks++; if (zero !== 1'b0) begin errors++; $display("[TB] FAIL after_ndef_zero: got %b want 0", zero); end
    nextCycle();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    applyStimulus(1'b1, XOR, 32'hF0, 32'hFF);
    nextCycle();
    // A second op waits upstream the whole time the XOR result is stalled.
    applyStimulus(1'b1, ADD, 32'h1, 32'h1);
    for (int k = 0; k < 5; k++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid[%0d]: got %b want 1", k, out_valid); end
      checks++; if (result !== 32'h0F) begin errors++; $display("[TB] FAIL bp_result[%0d]: got %h want 0000000f", k, result); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready[%0d]: got %b want 0", k, in_ready); end
      nextCycle();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_ready: got %b want 1", in_ready); end
    nextCycle();
    applyStimulus(1'b0, 4'd0, 32'h0, 32'h0);
    checks++; if (out_valid !== 1'b1 || result !== 32'h2) begin errors++; $display("[TB] FAIL bp_replace: got valid=%b result=%h want valid=1 result=00000002", out_valid, result); end
    nextCycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_shift_hold();
    bit seen = 1'b0;
    out_ready = 1'b0;
    applyStimulus(1'b1, SLL, 32'h3, 32'h2);
    for (int c = 1; c <= 64 && !seen; c++) begin
      nextCycle();
      if (c == 1) applyStimulus(1'b0, 4'd0, 32'h0, 32'h0);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("[TB] FAIL hold_timeout: got no out_valid in 64 cycles want 1"); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (result !== 32'hC || out_valid !== 1'b1) begin errors++; $display("[TB] FAIL hold_stable[%0d]: got valid=%b result=%h want valid=1 result=0000000c", k, out_valid, result); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL hold_in_ready[%0d]: got %b want 0", k, in_ready); end
      nextCycle();
    end
    out_ready = 1'b1;
    nextCycle();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL hold_release: got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid_shift();
    int spurious = 0;
    applyStimulus(1'b1, SRL, 32'hFFFF_FFFF, 32'h14);
    nextCycle();
    applyStimulus(1'b0, 4'd0, 32'h0, 32'h0);
    repeat (4) nextCycle();
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_ready: got %b want 1", in_ready); end
    nextCycle();
    rst = 1'b0;
    nextCycle();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_release_ready: got %b want 1", in_ready); end
    for (int c = 0; c < 25; c++) begin
      if (out_valid !== 1'b0) spurious++;
      nextCycle();
    end
    checks++; if (spurious != 0) begin errors++; $display("[TB] FAIL rst_abandon: got %0d valid cycles want 0", spurious); end
    applyStimulus(1'b1, ADD, 32'h7, 32'h8);
    nextCycle();
    applyStimulus(1'b0, 4'd0, 32'h0, 32'h0);
    checks++; if (out_valid !== 1'b1 || result !== 32'hF) begin errors++; $display("[TB] FAIL rst_fresh_add: got valid=%b result=%h want valid=1 result=0000000f", out_valid, result); end
    nextCycle();
  endtask

  initial begin
    $display("[TB] alu_exec_unit bench, fast shift build = %0d", FAST);
    test_reset();
    test_back_to_back();
    test_sub_slt();
    test_shift();
    test_illegal();
    test_backpressure();
    test_shift_hold();
    test_reset_mid_shift();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global bound so a wedged handshake can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got simulation still running want finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
